led_bank: RTL and testbench

LED_BANK -- requirements
Module: led_bank

---
 rtl/led_bank_pkg.sv | 13 +
 rtl/led_bank_chan.sv | 109 ++++++++++
 rtl/led_bank.sv | 85 ++++++++
 tb/tb_led_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bank_pkg.sv
// Shared types and constants for the LED bank: mode encoding and config channel index width.
package led_bank_pkg;

    localparam int CHAN_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

endpackage

// File: rtl/led_bank_chan.sv
// One LED channel: shadow config written by the host, active config committed at frame
// boundaries, and the registered LED drive derived from the active config and base counter.
module led_bank_chan
    import led_bank_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DIV_W = 5,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             frame_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             wr_i,
    input  mode_e            mode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pending_o,
    output logic             led_o
);

    localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    mode_e            sh_mode_q, sh_mode_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic [PWM_W-1:0] sh_duty_q, sh_duty_d;
    mode_e            act_mode_q, act_mode_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [PWM_W-1:0] act_duty_q, act_duty_d;
    logic             pending_q, pending_d;
    logic             led_q, led_d;
    logic [IDX_W-1:0] div_idx;
    logic             drive;

    // Dividers beyond the counter width saturate at the counter MSB.
    always_comb begin
        if (int'(act_div_q) >= CNT_W) begin
            div_idx = IDX_W'(CNT_W - 1);
        end else begin
            div_idx = IDX_W'(act_div_q);
        end
    end

    always_comb begin
        drive = 1'b0;
        case (act_mode_q)
            MODE_OFF:   drive = 1'b0;
            MODE_ON:    drive = 1'b1;
            MODE_BLINK: drive = cnt_i[div_idx];
            MODE_PWM:   drive = (cnt_i[PWM_W-1:0] < act_duty_q);
            default:    drive = 1'b0;
        endcase
    end

    // A write is only accepted while nothing is pending, so commit and write never collide;
    // a write landing on a boundary cycle therefore waits for the following boundary.
    always_comb begin
        sh_mode_d  = sh_mode_q;
        sh_div_d   = sh_div_q;
        sh_duty_d  = sh_duty_q;
        act_mode_d = act_mode_q;
        act_div_d  = act_div_q;
        act_duty_d = act_duty_q;
        pending_d  = pending_q;
        led_d      = led_q;
        if (frame_i && pending_q) begin
            act_mode_d = sh_mode_q;
            act_div_d  = sh_div_q;
            act_duty_d = sh_duty_q;
            pending_d  = 1'b0;
        end
        if (wr_i) begin
            sh_mode_d = mode_i;
            sh_div_d  = div_i;
            sh_duty_d = duty_i;
            pending_d = 1'b1;
        end
        if (en_i) begin
            led_d = drive;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode_q  <= MODE_OFF;
            sh_div_q   <= '0;
            sh_duty_q  <= '0;
            act_mode_q <= MODE_OFF;
            act_div_q  <= '0;
            act_duty_q <= '0;
            pending_q  <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            sh_mode_q  <= sh_mode_d;
            sh_div_q   <= sh_div_d;
            sh_duty_q  <= sh_duty_d;
            act_mode_q <= act_mode_d;
            act_div_q  <= act_div_d;
            act_duty_q <= act_duty_d;
            pending_q  <= pending_d;
            led_q      <= led_d;
        end
    end

    assign pending_o = pending_q;
    assign led_o     = led_q;

endmodule

// File: rtl/led_bank.sv
// LED bank top: free-running base counter, config write handshake with per-channel
// back-pressure, out-of-range error pulse, and NUM_CH channel instances.
module led_bank
    import led_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int DIV_W  = 5,
    parameter int PWM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [1:0]        cfg_mode,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] led_out
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cfg_err_q, cfg_err_d;
    logic              chan_oob;
    logic              chan_busy;
    logic              accept;
    logic              frame;
    logic [NUM_CH-1:0] chan_hit;
    logic [NUM_CH-1:0] chan_wr;

    assign chan_oob  = (32'(cfg_chan) >= 32'(NUM_CH));
    assign chan_busy = |(pending & chan_hit);
    assign cfg_ready = !rst && (chan_oob || !chan_busy);
    assign accept    = cfg_valid && cfg_ready;
    assign frame     = en && (&cnt_q[PWM_W-1:0]);

    always_comb begin
        cnt_d     = cnt_q;
        cfg_err_d = accept && chan_oob;
        if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign chan_hit[gi] = (cfg_chan == CHAN_W'(gi));
            assign chan_wr[gi]  = accept && chan_hit[gi];

            led_bank_chan #(
                .CNT_W (CNT_W),
                .DIV_W (DIV_W),
                .PWM_W (PWM_W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .en_i      (en),
                .frame_i   (frame),
                .cnt_i     (cnt_q),
                .wr_i      (chan_wr[gi]),
                .mode_i    (mode_e'(cfg_mode)),
                .div_i     (cfg_div),
                .duty_i    (cfg_duty),
                .pending_o (pending[gi]),
                .led_o     (led_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_bank.sv
// Self-checking bench for led_bank: cycle-level reference model feeding an expectation queue,
// plus directed measurements of blink period, PWM duty and handshake corner cases.
module tb_led_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int DIV_W  = 5;
    localparam int PWM_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_chan;
    logic [1:0]        cfg_mode;
    logic [DIV_W-1:0]  cfg_div;
    logic [PWM_W-1:0]  cfg_duty;
    logic              cfg_err;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] led_out;

    led_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DIV_W  (DIV_W),
        .PWM_W  (PWM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .pending   (pending),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] pend;
        logic              err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [CNT_W-1:0]  m_cnt;
    logic [NUM_CH-1:0] m_pend;
    logic [NUM_CH-1:0] m_led;
    logic              m_err;
    logic [1:0]        a_mode[NUM_CH];
    logic [DIV_W-1:0]  a_div[NUM_CH];
    logic [PWM_W-1:0]  a_duty[NUM_CH];
    logic [1:0]        s_mode[NUM_CH];
    logic [DIV_W-1:0]  s_div[NUM_CH];
    logic [PWM_W-1:0]  s_duty[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic led_fn(input logic [1:0] mode, input logic [DIV_W-1:0] div,
                                    input logic [PWM_W-1:0] duty, input logic [CNT_W-1:0] cnt);
        int idx;
        idx = (int'(div) >= CNT_W) ? CNT_W - 1 : int'(div);
        case (mode)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return cnt[idx];
            default: return (cnt[PWM_W-1:0] < duty);
        endcase
    endfunction

    task automatic model_reset();
        m_cnt  = '0;
        m_pend = '0;
        m_led  = '0;
        m_err  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            a_mode[c] = 2'd0; a_div[c] = '0; a_duty[c] = '0;
            s_mode[c] = 2'd0; s_div[c] = '0; s_duty[c] = '0;
        end
    endtask

    // One clock cycle: check ready, advance model, push expectation, clock, pop and compare.
    task automatic tick();
        exp_t e;
        logic rdy, acc, oob, bnd;
        int   ch;
        #1;
        ch  = int'(cfg_chan);
        oob = (ch >= NUM_CH);
        rdy = 1'b0;
        if (!rst) begin
            if (oob) rdy = 1'b1;
            else     rdy = !m_pend[ch];
        end
        check("cfg_ready", 32'(cfg_ready), 32'(rdy));
        acc = cfg_valid && rdy;
        if (rst) begin
            model_reset();
        end else begin
            bnd = en && (m_cnt[PWM_W-1:0] == '1);
            if (en) begin
                for (int c = 0; c < NUM_CH; c++)
                    m_led[c] = led_fn(a_mode[c], a_div[c], a_duty[c], m_cnt);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (bnd && m_pend[c]) begin
                    a_mode[c] = s_mode[c]; a_div[c] = s_div[c]; a_duty[c] = s_duty[c];
                    m_pend[c] = 1'b0;
                end
            end
            if (acc && !oob) begin
                s_mode[ch] = cfg_mode; s_div[ch] = cfg_div; s_duty[ch] = cfg_duty;
                m_pend[ch] = 1'b1;
            end
            m_err = acc && oob;
            if (en) m_cnt = m_cnt + 1;
        end
        e.led  = m_led;
        e.pend = m_pend;
        e.err  = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("led_out", 32'(led_out), 32'(e.led));
        check("pending", 32'(pending), 32'(e.pend));
        check("cfg_err", 32'(cfg_err), 32'(e.err));
    endtask

    task automatic write(input int ch, input int mode, input int div, input int duty);
        cfg_valid = 1'b1;
        cfg_chan  = 4'(ch);
        cfg_mode  = 2'(mode);
        cfg_div   = DIV_W'(div);
        cfg_duty  = PWM_W'(duty);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_commit(input int ch);
        for (int i = 0; i < 600 && m_pend[ch]; i++) tick();
        check("commit_done", 32'(pending[ch]), 32'd0);
    endtask

    initial begin
        int sum, run, toggles, duties[3];
        logic prev;
        rst = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_chan = '0;
        cfg_mode = '0; cfg_div = '0; cfg_duty = '0;
        model_reset();

        repeat (10) tick();
        check("rst_led", 32'(led_out), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_pending", 32'(pending), 32'd0);

        // Blink div=3: 8-cycle half period, starting at cnt=0 right after commit.
        write(0, 2, 3, 0);
        wait_commit(0);
        tick();
        check("blink_start", 32'(led_out[0]), 32'd0);
        prev = led_out[0]; run = 1; toggles = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (led_out[0] != prev) begin
                check("blink_run", 32'(run), 32'd8);
                toggles++; run = 1; prev = led_out[0];
            end else begin
                run++;
            end
        end
        check("blink_toggles", 32'(toggles), 32'd7);

        duties[0] = 64; duties[1] = 0; duties[2] = 255;
        for (int d = 0; d < 3; d++) begin
            write(1, 3, 0, duties[d]);
            wait_commit(1);
            sum = 0;
            for (int i = 0; i < 256; i++) begin
                tick();
                sum += int'(led_out[1]);
            end
            check("pwm_high", 32'(sum), 32'(duties[d]));
        end

        // Second ch2 write is back-pressured; ch3 is still accepted meanwhile.
        write(2, 1, 0, 0);
        write(2, 0, 0, 0);
        write(3, 2, 1, 0);
        check("pend_2_3", 32'(pending), 32'b1100);
        cfg_chan = 4'd2;
        wait_commit(2);
        wait_commit(3);

        // A write landing on a boundary cycle must wait for the next boundary.
        for (int i = 0; i < 300 && m_cnt[PWM_W-1:0] != '1; i++) tick();
        write(3, 3, 0, 128);
        check("bnd_hold", 32'(pending[3]), 32'd1);
        wait_commit(3);

        write(5, 1, 0, 0);
        check("err_pulse", 32'(cfg_err), 32'd1);
        check("err_pend", 32'(pending), 32'd0);
        tick();
        check("err_clear", 32'(cfg_err), 32'd0);

        write(2, 0, 0, 0);
        check("pend_0100", 32'(pending), 32'b0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_led2", 32'(led_out), 32'd0);

        write(0, 1, 0, 0);
        wait_commit(0);
        tick();
        en = 1'b0;
        write(1, 1, 0, 0);
        repeat (100) tick();
        check("freeze_led", 32'(led_out), 32'b0001);
        check("freeze_pend", 32'(pending), 32'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
